// File: rtl/fifo_wr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin arbiter sharing the enqueue side of a single-entry
//            FIFO (D_IN/ENQ/CLR/FULL_N) between NREQ producers. Also sequences
//            FIFO flushes (RUN -> CLR -> DONE -> RUN) and keeps a saturating
//            count of accepted enqueues for debug.
// Ports    : CLK, RST (async, active-high)
//            REQ_VALID/REQ_DATA/REQ_READY : producer handshake (zero latency)
//            FIFO_D_IN/FIFO_ENQ/FIFO_FULL_N/FIFO_CLR : FIFO enqueue side
//            FLUSH_REQ/FLUSH_DONE : flush request level / completion pulse
//            GRANT_ID, BUSY, ENQ_COUNT : status
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 1,
  parameter int IDW   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ_VALID,
  input  logic [NREQ*WIDTH-1:0] REQ_DATA,
  output logic [NREQ-1:0]       REQ_READY,
  output logic [WIDTH-1:0]      FIFO_D_IN,
  output logic                  FIFO_ENQ,
  input  logic                  FIFO_FULL_N,
  output logic                  FIFO_CLR,
  input  logic                  FLUSH_REQ,
  output logic                  FLUSH_DONE,
  output logic [IDW-1:0]        GRANT_ID,
  output logic                  BUSY,
  output logic [15:0]           ENQ_COUNT
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_CLR  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDW:0]   C_NREQ_W = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] C_LAST   = IDW'(NREQ - 1);

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [15:0]    cnt_q, cnt_d;

  logic [2*NREQ-1:0] w_rot;
  logic              w_found;
  logic [IDW-1:0]    w_off;
  logic [IDW:0]      w_sum;
  logic [IDW-1:0]    w_winner;
  logic              w_enq;

  // Rotate the request vector so that the rr pointer lands at bit 0; the
  // first set bit then gives the offset of the winner from the pointer.
  always_comb begin
    w_rot   = {REQ_VALID, REQ_VALID} >> rr_q;
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = IDW'(k);
      end
    end
    w_sum = {1'b0, rr_q} + {1'b0, w_off};
    if (w_sum >= C_NREQ_W) begin
      w_sum = w_sum - C_NREQ_W;
    end
    w_winner = w_sum[IDW-1:0];
  end

  // Grants only in RUN with no pending flush. RST gating keeps every output
  // at zero as soon as reset rises, before any clock edge.
  assign w_enq = !RST && (state_q == S_RUN) && !FLUSH_REQ && w_found && FIFO_FULL_N;

  assign FIFO_ENQ   = w_enq;
  assign REQ_READY  = w_enq ? (NREQ'(1) << w_winner) : '0;
  assign FIFO_D_IN  = w_enq ? REQ_DATA[int'(w_winner)*WIDTH +: WIDTH] : '0;
  assign GRANT_ID   = w_enq ? w_winner : '0;
  assign FIFO_CLR   = (state_q == S_CLR);
  assign FLUSH_DONE = (state_q == S_DONE);
  assign BUSY       = (state_q != S_RUN);
  assign ENQ_COUNT  = cnt_q;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (FLUSH_REQ) begin
          state_d = S_CLR;
        end else if (w_enq) begin
          rr_d = (w_winner == C_LAST) ? '0 : w_winner + 1'b1;
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_CLR: begin
        cnt_d   = '0;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_RUN;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_fifo_wr_arbiter
// Purpose  : Self-checking bench for fifo_wr_arbiter (NREQ=4, WIDTH=8, IDW=2).
//            A behavioural model predicts every output each cycle; directed
//            literal checks pin the model on the key scenarios.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      fifo_d_in;
  logic                  fifo_enq;
  logic                  fifo_full_n = 1'b1;
  logic                  fifo_clr;
  logic                  flush_req = 1'b0;
  logic                  flush_done;
  logic [IDW-1:0]        grant_id;
  logic                  busy;
  logic [15:0]           enq_count;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .CLK        (clk),
    .RST        (rst),
    .REQ_VALID  (req_valid),
    .REQ_DATA   (req_data),
    .REQ_READY  (req_ready),
    .FIFO_D_IN  (fifo_d_in),
    .FIFO_ENQ   (fifo_enq),
    .FIFO_FULL_N(fifo_full_n),
    .FIFO_CLR   (fifo_clr),
    .FLUSH_REQ  (flush_req),
    .FLUSH_DONE (flush_done),
    .GRANT_ID   (grant_id),
    .BUSY       (busy),
    .ENQ_COUNT  (enq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = running, 1 = clearing, 2 = reporting done
  int m_phase = 0, m_ptr = 0, m_cnt = 0;
  int n_phase = 0, n_ptr = 0, n_cnt = 0;

  always @(negedge clk) begin
    int w, e_ready, e_din, e_gid, e_enq;
    w = -1;
    e_enq = 0;
    if (!rst && m_phase == 0 && !flush_req && fifo_full_n) begin
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      e_enq = (w >= 0) ? 1 : 0;
    end
    e_ready = e_enq ? (1 << w) : 0;
    e_din   = e_enq ? int'(req_data[w*WIDTH +: WIDTH]) : 0;
    e_gid   = e_enq ? w : 0;

    n_tests++;
    if (fifo_enq !== 1'(e_enq) || req_ready !== 4'(e_ready) || fifo_d_in !== 8'(e_din) ||
        grant_id !== 2'(e_gid) || fifo_clr !== 1'(!rst && m_phase == 1) ||
        flush_done !== 1'(!rst && m_phase == 2) || busy !== 1'(!rst && m_phase != 0) ||
        enq_count !== 16'(rst ? 0 : m_cnt)) begin
      n_fail++;
      $display("FAIL model: enq=%b rdy=%b din=%h gid=%0d clr=%b done=%b busy=%b cnt=%0d expected enq=%0d rdy=%0h din=%0h gid=%0d phase=%0d cnt=%0d at %0t",
               fifo_enq, req_ready, fifo_d_in, grant_id, fifo_clr, flush_done, busy, enq_count,
               e_enq, e_ready, e_din, e_gid, m_phase, m_cnt, $time);
    end

    n_phase = m_phase; n_ptr = m_ptr; n_cnt = m_cnt;
    if (rst) begin
      n_phase = 0; n_ptr = 0; n_cnt = 0;
    end else if (m_phase == 0) begin
      if (flush_req) n_phase = 1;
      else if (e_enq != 0) begin
        n_ptr = (w + 1) % NREQ;
        n_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end
    end else if (m_phase == 1) begin
      n_phase = 2; n_cnt = 0;
    end else begin
      n_phase = 0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      m_phase = n_phase; m_ptr = n_ptr; m_cnt = n_cnt;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_gid [5] = '{0, 1, 2, 3, 0};
    logic [3:0] pats [4] = '{4'b1010, 4'b0110, 4'b1001, 4'b0011};

    repeat (3) tick();
    chk("reset_enq", 32'(fifo_enq), 0);
    chk("reset_cnt", 32'(enq_count), 0);

    // release with requester 0 only
    rst = 1'b0; req_valid = 4'b0001; fifo_full_n = 1'b1;
    #1;
    chk("post_reset_enq", 32'(fifo_enq), 1);
    chk("post_reset_gid", 32'(grant_id), 0);
    chk("post_reset_ready", 32'(req_ready), 32'b0001);
    tick();
    chk("post_reset_cnt", 32'(enq_count), 1);

    // reset asserted between edges: outputs drop immediately
    rst = 1'b1;
    #1;
    chk("midcycle_rst_enq", 32'(fifo_enq), 0);
    chk("midcycle_rst_ready", 32'(req_ready), 0);
    chk("midcycle_rst_cnt", 32'(enq_count), 0);
    tick();
    rst = 1'b0; req_valid = 4'b0000;
    tick();

    // fairness: all four requesting
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("fair_gid", 32'(grant_id), 32'(exp_gid[i]));
      tick();
    end
    chk("fair_cnt", 32'(enq_count), 5);
    req_valid = 4'b0000;
    tick();

    // backpressure on requester 2
    req_valid = 4'b0100; fifo_full_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready_low", 32'(req_ready), 0);
      tick();
    end
    fifo_full_n = 1'b1;
    #1;
    chk("bp_ready", 32'(req_ready), 32'b0100);
    chk("bp_din", 32'(fifo_d_in), 32'h33);
    tick();
    chk("bp_cnt", 32'(enq_count), 6);
    req_valid = 4'b0000;
    tick();

    // flush beats a simultaneous request
    flush_req = 1'b1; req_valid = 4'b0001;
    #1;
    chk("flush_no_enq", 32'(fifo_enq), 0);
    tick();
    flush_req = 1'b0;
    #1;
    chk("flush_clr", 32'(fifo_clr), 1);
    chk("flush_busy", 32'(busy), 1);
    tick();
    chk("flush_done", 32'(flush_done), 1);
    chk("flush_cnt", 32'(enq_count), 0);
    tick();
    chk("flush_resume_enq", 32'(fifo_enq), 1);
    chk("flush_resume_gid", 32'(grant_id), 0);
    tick();
    chk("flush_resume_cnt", 32'(enq_count), 1);
    req_valid = 4'b0000;

    // reset during CLR aborts the flush
    flush_req = 1'b1;
    tick();
    chk("abort_in_clr", 32'(fifo_clr), 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cnt", 32'(enq_count), 0);
    tick();
    rst = 1'b0; flush_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("abort_no_done", 32'(flush_done), 0);
      tick();
    end

    // mixed patterns with intermittent backpressure (model-checked)
    for (int i = 0; i < 16; i++) begin
      req_valid   = pats[i % 4];
      fifo_full_n = (i % 3) != 2;
      tick();
    end
    req_valid = 4'b0000; fifo_full_n = 1'b1;
    tick();

    // saturation
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = 4'b0001;
    repeat (65537) tick();
    chk("sat_cnt", 32'(enq_count), 32'hFFFF);
    tick();
    chk("sat_hold", 32'(enq_count), 32'hFFFF);
    req_valid = 4'b0000;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the enqueue port of a single-entry FIFO (FIFO1: D_IN/ENQ/CLR/FULL_N) between NREQ independent producers.
- Also sequences FIFO flushes: on a flush request it blocks grants, pulses the FIFO clear, then acknowledges completion.
- Keeps a saturating count of accepted enqueues for debug.
- Sits between the producer blocks and the FIFO instance. The consumer side (DEQ/EMPTY_N) is not touched.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 1, data width per requester; matches FIFO width.
- IDW, 2, width of GRANT_ID; must satisfy 2**IDW >= NREQ.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; asynchronous, active-high.
- REQ_VALID  input  NREQ  per-requester valid.
- REQ_DATA  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- REQ_READY  output  NREQ  per-requester accept; one-hot or zero.
- FIFO_D_IN  output  WIDTH  data to FIFO D_IN.
- FIFO_ENQ  output  1  FIFO enqueue strobe.
- FIFO_FULL_N  input  1  FIFO has space when high.
- FIFO_CLR  output  1  FIFO clear strobe.
- FLUSH_REQ  input  1  level request to flush the FIFO.
- FLUSH_DONE  output  1  one-cycle pulse when the flush completes.
- GRANT_ID  output  IDW  index of the current winner; valid when FIFO_ENQ is high.
- BUSY  output  1  high while the FSM is not in RUN.
- ENQ_COUNT  output  16  accepted enqueues since reset or the last flush; saturating.

Behaviour:
- Reset (async on RST high):
  - state = RUN, rr pointer = 0, ENQ_COUNT = 0.
  - REQ_READY = 0, FIFO_ENQ = 0, FIFO_CLR = 0, FLUSH_DONE = 0, BUSY = 0, GRANT_ID = 0.
  - Reset mid-flush aborts the flush; no FLUSH_DONE is issued.
- FSM states: RUN -> CLR -> DONE -> RUN.
  - RUN: if FLUSH_REQ is high, go to CLR. No grant is issued in that cycle; flush beats enqueue.
  - CLR: FIFO_CLR = 1 for exactly one cycle; ENQ_COUNT <= 0; go to DONE.
  - DONE: FLUSH_DONE = 1 for one cycle; go to RUN.
  - FLUSH_REQ held high on return to RUN starts another flush immediately. Requesters must drop it after FLUSH_DONE.
  - BUSY = (state != RUN).
- Arbitration (combinational, RUN only, FLUSH_REQ low):
  - Winner = first i with REQ_VALID[i] set, searching from the rr pointer upward modulo NREQ.
  - FIFO_ENQ = any valid & FIFO_FULL_N.
  - REQ_READY[winner] = FIFO_ENQ; all other REQ_READY bits are 0.
  - FIFO_D_IN = winner's data when FIFO_ENQ is high, else 0.
  - GRANT_ID = winner index when FIFO_ENQ is high, else 0.
  - Zero-latency handshake: a transfer occurs in any cycle with REQ_VALID[i] & REQ_READY[i].
- Pointer update: on a transfer, rr pointer <= (winner + 1) mod NREQ. With no transfer the pointer holds.
- Full FIFO (FIFO_FULL_N low): no ENQ, no READY, pointer holds. Requesters keep VALID and data stable until accepted.
- ENQ_COUNT: increments by 1 per transfer and saturates at 0xFFFF. It is cleared only in the CLR state or by reset.
- Outside RUN: REQ_READY = 0 and FIFO_ENQ = 0 regardless of FIFO_FULL_N.
- Throughput: at most one enqueue per cycle. Against FIFO1 the effective rate is one enqueue per dequeue.

Test Plan:
- Reset: RST pulse asserted between clock edges -> all outputs 0 immediately, without waiting for an edge. After release with REQ_VALID=0001 and FULL_N=1 -> FIFO_ENQ=1, GRANT_ID=0, REQ_READY=0001.
- Fairness: NREQ=4, REQ_VALID=1111 held, FULL_N=1 every cycle -> GRANT_ID sequence 0,1,2,3,0 and ENQ_COUNT=5 after 5 cycles.
- Backpressure: REQ_VALID=0100, FULL_N=0 for 3 cycles then 1 -> no READY for 3 cycles, then READY[2] in cycle 4. FIFO_D_IN equals REQ_DATA[2] and ENQ_COUNT increments by exactly 1.
- Flush priority: FLUSH_REQ=1 in the same cycle as REQ_VALID=0001 and FULL_N=1 -> no ENQ that cycle. Next cycle FIFO_CLR=1 and BUSY=1, then FLUSH_DONE=1. ENQ_COUNT=0; the grant resumes in the following RUN cycle.
- Reset mid-flush: RST asserted while in CLR -> state RUN, FLUSH_DONE never pulses, ENQ_COUNT=0.
- Saturation: force 65537 transfers -> ENQ_COUNT stays 0xFFFF.
